// File: rtl/activation_feeder_if.sv
// activation_feeder_if: controller, activation-memory read port and array west-edge signals of the feeder.
interface activation_feeder_if #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ACTIVATION_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(SYSTOLIC_SIZE)
);
    logic start;
    logic [ADDR_WIDTH:0] num_rows;
    logic stall;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] rd_data;
    logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_out;
    logic [SYSTOLIC_SIZE-1:0] act_valid;
    logic busy;
    logic done;
    modport master (output start, num_rows, stall, rd_data, input rd_addr, act_out, act_valid, busy, done);
    modport slave (input start, num_rows, stall, rd_data, output rd_addr, act_out, act_valid, busy, done);
endinterface

// File: rtl/activation_feeder.sv
// activation_feeder: walks activation memory rows and feeds them diagonally skewed
// into the systolic array west edge (lane i delayed by i cycles).
module activation_feeder #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ACTIVATION_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(SYSTOLIC_SIZE)
) (
    input logic clk,
    input logic rst_n,
    activation_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, last;
    logic [ADDR_WIDTH:0] eff;
    logic feeding, feed_end, drain_end;
    assign feeding = state == FEED;
    assign eff = (bus.num_rows == '0 || bus.num_rows > (ADDR_WIDTH+1)'(SYSTOLIC_SIZE)) ?
                 (ADDR_WIDTH+1)'(SYSTOLIC_SIZE) : bus.num_rows;
    assign feed_end = cnt == last;
    assign drain_end = cnt == ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else if (!bus.stall) state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = FEED;
            FEED: if (feed_end) state_nx = DRAIN;
            DRAIN: if (drain_end) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.rd_addr = feeding ? cnt : (state == IDLE) ? '0 : last;
        bus.busy = feeding || state == DRAIN;
        bus.done = state == DONE;
    end
    // One counter serves as row index in FEED and drain timer in DRAIN; it restarts on every state change.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            last <= '0;
        end else if (!bus.stall) begin
            if (state == IDLE && bus.start) last <= ADDR_WIDTH'(eff - 1'b1);
            cnt <= (state == state_nx) ? cnt + 1'b1 : '0;
        end
    for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
        logic [ACTIVATION_WIDTH-1:0] d [i+1];
        logic [i:0] v;
        // Zeros are shifted in outside FEED so idle lanes present zero-fill to the array.
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                v <= '0;
                for (int j = 0; j <= i; j++) d[j] <= '0;
            end else if (!bus.stall) begin
                v <= (i+1)'({v, feeding});
                d[0] <= feeding ? bus.rd_data[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] : '0;
                for (int j = 1; j <= i; j++) d[j] <= d[j-1];
            end
        assign bus.act_out[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] = d[i];
        assign bus.act_valid[i] = v[i];
    end
endmodule
